rs_dec_syndrome: RTL and testbench

Receive-side front end of the RS(255,239,T=8) GF(2^8) code used by `rs_enc`. It takes a received codeword as a contiguous byte burst and forwards the information bytes with the 2T parity bytes stripped. At the end of each codeword it emits the 2T syndromes S_j = r(λ^j), j = 0..2T-1, with a block error flag. It feeds the downstream key-equation/Chien stage and is the first block of the RS decoder.

---
 rtl/rs_dec_syndrome.sv | 196 +++++++++++++++++++
 tb/tb_rs_dec_syndrome.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dec_syndrome.sv
// RS(255,239) receive front end: strips the 2T parity bytes from each burst and
// emits the 2T Horner-evaluated syndromes plus block error flags at burst end.
module rs_dec_syndrome #(
    parameter int W = 8,
    parameter int T = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_bits,
    input  logic         in_valid,
    output logic [W-1:0] out_bits,
    output logic         out_valid,
    output logic [W-1:0] syn_out,
    output logic [3:0]   syn_idx,
    output logic         syn_valid,
    output logic         err,
    output logic         len_err,
    output logic         blk_done
);

    localparam int             NSYN     = 2 * T;
    localparam int             CW       = 9;
    localparam logic [CW-1:0]  CNT_SAT  = 9'd256;
    localparam logic [CW-1:0]  CNT_NSYN = CW'(NSYN);
    localparam logic [CW-1:0]  MIN_LEN  = CW'(NSYN + 1);
    localparam logic [CW-1:0]  MAX_LEN  = 9'd255;
    localparam logic [3:0]     LAST_IDX = 4'(NSYN - 1);
    localparam logic [W-1:0]   POLY_LO  = W'(8'h1D);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    function automatic logic [W-1:0] gf_xtime(input logic [W-1:0] a);
        return {a[W-2:0], 1'b0} ^ (a[W-1] ? POLY_LO : '0);
    endfunction

    // Constant multiply by lambda^n; n is elaboration-time so this is a pure XOR net.
    function automatic logic [W-1:0] gf_mul_pow(input logic [W-1:0] a, input int n);
        logic [W-1:0] r;
        r = a;
        for (int k = 0; k < n; k++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    logic [W-1:0]  acc_q   [NSYN];
    logic [W-1:0]  acc_d   [NSYN];
    logic [W-1:0]  acc_mul [NSYN];
    logic [W-1:0]  dly_q   [NSYN];
    logic [W-1:0]  dly_d   [NSYN];
    logic [W-1:0]  snap_q  [NSYN];
    logic [NSYN-1:0] acc_nz;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    state_t        state_q;
    logic [3:0]    rd_idx_q;
    logic [W-1:0]  out_bits_q;
    logic          out_valid_q;
    logic [W-1:0]  syn_out_q;
    logic [3:0]    syn_idx_q;
    logic          syn_valid_q;
    logic          blk_done_q;
    logic          err_q;
    logic          len_err_q;

    logic          eob;
    logic          len_bad;
    logic          emit_data;

    generate
        for (genvar gi = 0; gi < NSYN; gi++) begin : g_syn
            assign acc_mul[gi] = gf_mul_pow(acc_q[gi], gi);
            assign acc_nz[gi]  = |acc_q[gi];
        end
    endgenerate

    assign eob       = !in_valid && (cnt_q != '0);
    assign len_bad   = (cnt_q < MIN_LEN) || (cnt_q > MAX_LEN);
    assign emit_data = in_valid && (cnt_q >= CNT_NSYN);

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NSYN; i++) begin
            acc_d[i] = acc_q[i];
            dly_d[i] = dly_q[i];
        end
        if (in_valid) begin
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 9'd1;
            end
            for (int i = 0; i < NSYN; i++) begin
                acc_d[i] = acc_mul[i] ^ in_bits;
            end
            dly_d[0] = in_bits;
            for (int i = 1; i < NSYN; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end else if (eob) begin
            // The bytes still in the delay line are parity and are dropped here.
            cnt_d = '0;
            for (int i = 0; i < NSYN; i++) begin
                acc_d[i] = '0;
                dly_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < NSYN; i++) begin
                acc_q[i] <= '0;
                dly_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < NSYN; i++) begin
                acc_q[i] <= acc_d[i];
                dly_q[i] <= dly_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_bits_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= emit_data;
            if (emit_data) begin
                out_bits_q <= dly_q[NSYN-1];
            end
        end
    end

    // Index 0 is driven straight from the accumulator on the end-of-burst edge so
    // syn_valid starts in the very next cycle; the rest come from the snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rd_idx_q    <= '0;
            syn_out_q   <= '0;
            syn_idx_q   <= '0;
            syn_valid_q <= 1'b0;
            blk_done_q  <= 1'b0;
            err_q       <= 1'b0;
            len_err_q   <= 1'b0;
            for (int i = 0; i < NSYN; i++) begin
                snap_q[i] <= '0;
            end
        end else if (eob) begin
            for (int i = 0; i < NSYN; i++) begin
                snap_q[i] <= acc_q[i];
            end
            syn_out_q   <= acc_q[0];
            syn_idx_q   <= '0;
            syn_valid_q <= 1'b1;
            blk_done_q  <= 1'b0;
            rd_idx_q    <= 4'd1;
            len_err_q   <= len_bad;
            err_q       <= len_bad || (|acc_nz);
            state_q     <= ST_DRAIN;
        end else begin
            case (state_q)
                ST_DRAIN: begin
                    syn_out_q   <= snap_q[rd_idx_q];
                    syn_idx_q   <= rd_idx_q;
                    syn_valid_q <= 1'b1;
                    blk_done_q  <= (rd_idx_q == LAST_IDX);
                    rd_idx_q    <= rd_idx_q + 4'd1;
                    if (rd_idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    syn_valid_q <= 1'b0;
                    blk_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_bits  = out_bits_q;
    assign out_valid = out_valid_q;
    assign syn_out   = syn_out_q;
    assign syn_idx   = syn_idx_q;
    assign syn_valid = syn_valid_q;
    assign blk_done  = blk_done_q;
    assign err       = err_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_rs_dec_syndrome.sv
// Directed, table-driven bench for rs_dec_syndrome: data stripping, syndromes,
// latencies, length errors, back-to-back bursts, drain restart and mid-burst reset.
module tb_rs_dec_syndrome;

    localparam int NSYN = 16;
    localparam int NV   = 11;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] in_bits  = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] out_bits;
    logic       out_valid;
    logic [7:0] syn_out;
    logic [3:0] syn_idx;
    logic       syn_valid;
    logic       err;
    logic       len_err;
    logic       blk_done;

    rs_dec_syndrome #(.W(8), .T(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bits   (in_bits),
        .in_valid  (in_valid),
        .out_bits  (out_bits),
        .out_valid (out_valid),
        .syn_out   (syn_out),
        .syn_idx   (syn_idx),
        .syn_valid (syn_valid),
        .err       (err),
        .len_err   (len_err),
        .blk_done  (blk_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int           kind;      // 0 all zero, 1 r(x)=x, 2 encoded payload 0,1,2..
        int           len;
        int           flip_pos;
        logic [7:0]   flip_val;
        int           gap;
        int           exp_out_n;
        logic [127:0] exp_syn;   // S_j in bits [8j+7:8j]
        logic         exp_err;
        logic         exp_len;
    } vec_t;

    vec_t       vecs [NV];
    logic [7:0] cw   [0:299];
    logic [7:0] gen  [0:16];

    logic [7:0] out_q[$];
    int         out_cyc_q[$];
    logic [7:0] exp_out_q[$];
    logic [7:0] syn_q[$];
    logic [3:0] sidx_q[$];
    logic       sdone_q[$];
    logic       serr_q[$];
    logic       slen_q[$];
    int         scyc_q[$];
    int         pend_v[$];
    int         pend_s[$];
    int         stray_done = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            out_q.push_back(out_bits);
            out_cyc_q.push_back(cyc);
        end
        if (syn_valid) begin
            syn_q.push_back(syn_out);
            sidx_q.push_back(syn_idx);
            sdone_q.push_back(blk_done);
            serr_q.push_back(err);
            slen_q.push_back(len_err);
            scyc_q.push_back(cyc);
        end
        if (blk_done && !syn_valid) stray_done++;
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] alpha_pow(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < (n % 255); i++) r = xtime(r);
        return r;
    endfunction

    // Syndromes of a single error of value e at coefficient degree deg.
    function automatic logic [127:0] flip_syn(input logic [7:0] e, input int deg);
        logic [127:0] s;
        s = '0;
        for (int j = 0; j < NSYN; j++) s[8*j +: 8] = gmul(e, alpha_pow(deg * j));
        return s;
    endfunction

    function automatic logic [127:0] tup(input int c, input int idx, input logic d,
                                         input logic e, input logic l, input logic [7:0] v);
        logic [3:0] i4;
        i4 = idx[3:0];
        return 128'({c, i4, d, e, l, v});
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic calc_gen();
        logic [7:0] a;
        for (int k = 0; k <= 16; k++) gen[k] = 8'h00;
        gen[0] = 8'h01;
        a = 8'h01;
        for (int j = 0; j < NSYN; j++) begin
            for (int k = j + 1; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], a);
            gen[0] = gmul(gen[0], a);
            a = xtime(a);
        end
    endtask

    task automatic encode(input int m);
        logic [7:0] par [16];
        logic [7:0] fb;
        for (int i = 0; i < 16; i++) par[i] = 8'h00;
        for (int k = 0; k < m; k++) begin
            fb = cw[k] ^ par[15];
            for (int i = 15; i >= 1; i--) par[i] = par[i-1] ^ gmul(fb, gen[i]);
            par[0] = gmul(fb, gen[0]);
        end
        for (int i = 0; i < 16; i++) cw[m+i] = par[15-i];
    endtask

    task automatic build(input int v);
        for (int k = 0; k < 300; k++) cw[k] = 8'h00;
        if (vecs[v].kind == 1) cw[vecs[v].len-2] = 8'h01;
        if (vecs[v].kind == 2) begin
            for (int k = 0; k < vecs[v].len - 16; k++) cw[k] = 8'(k);
            encode(vecs[v].len - 16);
        end
        if (vecs[v].flip_pos >= 0) cw[vecs[v].flip_pos] = vecs[v].flip_val;
    endtask

    task automatic send(input int len, input int gap, output int start);
        start = 0;
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_bits  = cw[k];
            if (k == 0) start = cyc + 1;
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_bits  = 8'h00;
        end
    endtask

    task automatic pop_syn(input string name, input logic [127:0] exp);
        if (syn_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got no syndrome expected %0h", name, exp);
        end else begin
            check(name, tup(scyc_q.pop_front(), int'(sidx_q.pop_front()), sdone_q.pop_front(),
                            serr_q.pop_front(), slen_q.pop_front(), syn_q.pop_front()), exp);
        end
    endtask

    task automatic check_pending();
        int v, s;
        logic [7:0] e;
        while (pend_v.size() > 0) begin
            v = pend_v.pop_front();
            s = pend_s.pop_front();
            for (int k = 0; k < vecs[v].exp_out_n; k++) begin
                e = exp_out_q.pop_front();
                if (out_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out v%0d b%0d: got no byte expected %0h", v, k, e);
                end else begin
                    check($sformatf("out v%0d b%0d", v, k),
                          128'({out_cyc_q.pop_front(), out_q.pop_front()}),
                          128'({s + 16 + k, e}));
                end
            end
            for (int j = 0; j < NSYN; j++) begin
                pop_syn($sformatf("syn v%0d j%0d", v, j),
                        tup(s + vecs[v].len + j, j, j == NSYN - 1, vecs[v].exp_err,
                            vecs[v].exp_len, vecs[v].exp_syn[8*j +: 8]));
            end
            $display("vec %0d: kind=%0d len=%0d out_bytes=%0d syndromes=%0d", v, vecs[v].kind,
                     vecs[v].len, vecs[v].exp_out_n, NSYN);
        end
        check("extra_out", 128'(out_q.size()), 128'(0));
        check("extra_syn", 128'(syn_q.size()), 128'(0));
    endtask

    task automatic run_vec(input int v);
        int s;
        build(v);
        for (int k = 0; k < vecs[v].exp_out_n; k++) exp_out_q.push_back(cw[k]);
        send(vecs[v].len, vecs[v].gap, s);
        pend_v.push_back(v);
        pend_s.push_back(s);
        if (vecs[v].gap > 1) check_pending();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] XS = {8'h26, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A, 8'h1D,
                                   8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    initial begin
        int sa, sb;
        logic [7:0] a_syn [4];
        calc_gen();
        vecs[0]  = '{0, 255, -1, 8'h00, 40, 239, 128'h0, 1'b0, 1'b0};
        vecs[1]  = '{1, 255, -1, 8'h00, 40, 239, XS,     1'b1, 1'b0};
        vecs[2]  = '{2,  52, -1, 8'h00, 40,  36, 128'h0, 1'b0, 1'b0};
        vecs[3]  = '{2,  52,  1, 8'hFF, 40,  36, flip_syn(8'hFE, 50), 1'b1, 1'b0};
        vecs[4]  = '{1, 255, -1, 8'h00,  1, 239, XS,     1'b1, 1'b0};
        vecs[5]  = '{2, 255, -1, 8'h00, 40, 239, 128'h0, 1'b0, 1'b0};
        vecs[6]  = '{0,  10, -1, 8'h00, 40,   0, 128'h0, 1'b1, 1'b1};
        vecs[7]  = '{1,  17, -1, 8'h00, 40,   1, XS,     1'b1, 1'b0};
        vecs[8]  = '{0,  16, -1, 8'h00, 40,   0, 128'h0, 1'b1, 1'b1};
        vecs[9]  = '{0, 256, -1, 8'h00, 40, 240, 128'h0, 1'b1, 1'b1};
        vecs[10] = '{0, 255, -1, 8'h00, 40, 239, 128'h0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 128'({out_bits, out_valid, syn_out, syn_idx, syn_valid, err,
                                   len_err, blk_done}), 128'(0));
        @(posedge clk); #1;
        reset = 1'b1;

        for (int v = 0; v < NV - 1; v++) run_vec(v);

        // Short burst ending while the previous short burst is still draining.
        for (int k = 0; k < 300; k++) cw[k] = 8'h00;
        cw[0] = 8'h01;
        send(3, 1, sa);
        cw[0] = 8'h00;
        cw[2] = 8'h05;
        send(3, 40, sb);
        a_syn[0] = 8'h01; a_syn[1] = 8'h04; a_syn[2] = 8'h10; a_syn[3] = 8'h40;
        check("restart_out", 128'(out_q.size()), 128'(0));
        check("restart_cnt", 128'(syn_q.size()), 128'(20));
        for (int j = 0; j < 4; j++)
            pop_syn($sformatf("restart a j%0d", j), tup(sa + 3 + j, j, 1'b0, 1'b1, 1'b1, a_syn[j]));
        for (int j = 0; j < NSYN; j++)
            pop_syn($sformatf("restart b j%0d", j),
                    tup(sb + 3 + j, j, j == NSYN - 1, 1'b1, 1'b1, 8'h05));
        $display("seq restart: 3-byte burst cut by 3-byte burst, 4+16 syndromes");

        // Reset after byte 100 of a codeword.
        for (int k = 0; k < 300; k++) cw[k] = 8'(k + 1);
        send(100, 0, sa);
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_bits  = 8'h00;
        #1;
        check("reset_mid", 128'({out_bits, out_valid, syn_out, syn_idx, syn_valid, err,
                                 len_err, blk_done}), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_syn", 128'(syn_q.size()), 128'(0));
        out_q.delete();
        out_cyc_q.delete();
        $display("seq reset: codeword aborted after byte 100");
        run_vec(NV - 1);

        check("stray_blk_done", 128'(stray_done), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
